// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the memory access stage: FSM states,
// funct3 size encodings, pipeline control and the Memory->Writeback payload.
package memory_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } memState_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Hazard-unit control for a pipeline register.
    typedef struct packed {
        logic stall;
        logic flush;
    } pipeControl_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] data;
    } mwPayload_t;

endpackage

// File: rtl/memory_access_stage_align.sv
// Byte-lane logic for the memory stage: store strobes/data replication,
// load extraction with sign/zero extension, and misalignment detection.
module load_store_align
    import memory_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] storeData,
    input  logic [31:0] loadWord,
    output logic [3:0]  strobe,
    output logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [31:0] shifted;

    // NOTE: every output of an always_comb block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = byteOffset[0];
            F3_LW:         misaligned = |byteOffset;
            default:       misaligned = 1'b1;
        endcase
    end

    always_comb begin
        strobe = 4'b1111;
        wdata  = storeData;
        case (funct3)
            F3_SB: begin
                strobe = 4'b0001 << byteOffset;
                wdata  = {4{storeData[7:0]}};
            end
            F3_SH: begin
                strobe = 4'b0011 << byteOffset;
                wdata  = {2{storeData[15:0]}};
            end
            default: begin
                strobe = 4'b1111;
                wdata  = storeData;
            end
        endcase
    end

    assign shifted = loadWord >> {byteOffset, 3'b000};

    always_comb begin
        loadData = shifted;
        case (funct3)
            F3_LB:   loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  loadData = {24'h0, shifted[7:0]};
            F3_LHU:  loadData = {16'h0, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage of the 5-stage core: issues DMEM load/store requests, stalls
// the pipeline while an access is outstanding, and fills the MW register.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exValid,
    input  logic                  exIllegal,
    input  logic                  exIsLoad,
    input  logic                  exIsStore,
    input  logic [2:0]            exFunct3,
    input  logic [ADDR_WIDTH-1:0] exAddress,
    input  logic [DATA_WIDTH-1:0] exStoreData,
    input  logic [4:0]            exRd,
    input  logic                  exRegWrite,
    input  logic [DATA_WIDTH-1:0] exResult,
    input  pipeControl_t          mwControl,
    output logic                  dmemReqValid,
    input  logic                  dmemReqReady,
    output logic                  dmemReqWrite,
    output logic [ADDR_WIDTH-1:0] dmemReqAddr,
    output logic [DATA_WIDTH-1:0] dmemReqWdata,
    output logic [3:0]            dmemReqStrb,
    input  logic                  dmemRespValid,
    input  logic [DATA_WIDTH-1:0] dmemRespRdata,
    output logic                  stallControl,
    output logic                  mwValid,
    output logic                  mwIllegal,
    output logic                  mwRegWrite,
    output logic [4:0]            mwRd,
    output logic [DATA_WIDTH-1:0] mwData
);

    memState_t   state;
    memState_t   nextState;
    mwPayload_t  mwReg;
    mwPayload_t  mwNext;
    logic        isMem;
    logic        misaligned;
    logic        memOp;
    logic [3:0]  strobe;
    logic [31:0] laneData;
    logic [31:0] loadData;

    load_store_align alignUnit (
        .funct3     (exFunct3),
        .byteOffset (exAddress[1:0]),
        .storeData  (exStoreData),
        .loadWord   (dmemRespRdata),
        .strobe     (strobe),
        .wdata      (laneData),
        .loadData   (loadData),
        .misaligned (misaligned)
    );

    assign isMem = exIsLoad || exIsStore;
    assign memOp = exValid && !exIllegal && isMem && !misaligned;

    // Request fields come straight from the EX/MEM register, which the hazard
    // unit holds while stallControl is high, so they stay stable in REQ.
    assign dmemReqWrite = exIsStore;
    assign dmemReqAddr  = {exAddress[ADDR_WIDTH-1:2], 2'b00};
    assign dmemReqWdata = laneData;
    assign dmemReqStrb  = exIsStore ? strobe : 4'b0000;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        dmemReqValid = 1'b0;
        case (state)
            IDLE: begin
                if (memOp) begin
                    dmemReqValid = 1'b1;
                    nextState    = dmemReqReady ? WAIT : REQ;
                end
            end
            REQ: begin
                // Losing memOp here means EX/MEM was flushed by a trap.
                if (mwControl.flush || !memOp) begin
                    nextState = IDLE;
                end else begin
                    dmemReqValid = 1'b1;
                    if (dmemReqReady) nextState = WAIT;
                end
            end
            WAIT: begin
                if (dmemRespValid) begin
                    nextState = IDLE;
                end else if (mwControl.flush || !memOp) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (dmemRespValid) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (!reset) dmemReqValid = 1'b0;
    end

    assign stallControl = reset &&
                          ((memOp && !(state == WAIT && dmemRespValid)) ||
                           (state == DRAIN && exValid));

    always_comb begin
        mwNext          = '0;
        mwNext.valid    = exValid;
        mwNext.illegal  = exIllegal || (isMem && misaligned);
        mwNext.regWrite = exRegWrite && !exIsStore && (exRd != 5'd0);
        mwNext.rd       = exRd;
        mwNext.data     = (exIsLoad && memOp) ? loadData : exResult;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mwReg <= '0;
        end else if (mwControl.flush) begin
            // Only valid matters for a bubble; the rest is left as is.
            mwReg.valid <= 1'b0;
        end else if (!(mwControl.stall || stallControl)) begin
            mwReg <= mwNext;
        end
    end

    assign mwValid    = mwReg.valid;
    assign mwIllegal  = mwReg.illegal;
    assign mwRegWrite = mwReg.regWrite;
    assign mwRd       = mwReg.rd;
    assign mwData     = mwReg.data;

endmodule
